// File: rtl/key_pkg.sv
// Shared types for the pushbutton conditioner.
// Channel FSM encoding and parameter helpers.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce FSM,
// edge pulses and auto-repeat timer.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int RMAX = max2(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PERIOD);

  logic [1:0]    sync_q;
  logic          s;
  key_state_t    state, state_n;
  logic [DW-1:0] dcnt, dcnt_n, dinc;
  logic [RW-1:0] rcnt, rcnt_n, rinc;
  logic          rph, rph_n;
  logic          press_n, rel_n, rpt_n, level_n;

  assign s    = sync_q[1];
  assign dinc = dcnt + D_ONE;
  assign rinc = rcnt + R_ONE;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], key};
    end
  end

  // Debounce FSM: a new level must hold DEBOUNCE samples.
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    press_n = 1'b0;
    rel_n   = 1'b0;
    unique case (state)
      RELEASED: begin
        if (s) begin
          if (DEBOUNCE == 1) begin
            state_n = PRESSED;
            press_n = 1'b1;
            dcnt_n  = '0;
          end else begin
            state_n = PRESS_WAIT;
            dcnt_n  = D_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_n = RELEASED;
          dcnt_n  = '0;
        end else if (dinc == D_LAST) begin
          state_n = PRESSED;
          press_n = 1'b1;
          dcnt_n  = '0;
        end else begin
          dcnt_n = dinc;
        end
      end
      PRESSED: begin
        if (!s) begin
          if (DEBOUNCE == 1) begin
            state_n = RELEASED;
            rel_n   = 1'b1;
            dcnt_n  = '0;
          end else begin
            state_n = RELEASE_WAIT;
            dcnt_n  = D_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_n = PRESSED;
          dcnt_n  = '0;
        end else if (dinc == D_LAST) begin
          state_n = RELEASED;
          rel_n   = 1'b1;
          dcnt_n  = '0;
        end else begin
          dcnt_n = dinc;
        end
      end
      default: begin
        state_n = RELEASED;
        dcnt_n  = '0;
      end
    endcase
  end

  // Repeat timer: initial delay phase, then period phase;
  // frozen while a release is being debounced.
  always_comb begin
    rcnt_n = rcnt;
    rph_n  = rph;
    rpt_n  = 1'b0;
    if (!repeat_en || press_n) begin
      rcnt_n = '0;
      rph_n  = 1'b0;
    end else if (state == PRESSED && state_n != RELEASED) begin
      if (rinc == (rph ? R_PER : R_DLY)) begin
        rpt_n  = 1'b1;
        rcnt_n = '0;
        rph_n  = 1'b1;
      end else begin
        rcnt_n = rinc;
      end
    end
  end

  // Level covers the release-debounce window too.
  always_comb begin
    level_n = (state_n == PRESSED) ||
              (state_n == RELEASE_WAIT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      dcnt  <= '0;
      rcnt  <= '0;
      rph   <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      rpt   <= 1'b0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      rcnt  <= rcnt_n;
      rph   <= rph_n;
      level <= level_n;
      press <= press_n;
      rel   <= rel_n;
      rpt   <= rpt_n;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel pushbutton front end: one
// independent key_channel per key pin.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] level,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] rel,
  output logic [NUM_KEYS-1:0] rpt
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE     (DEBOUNCE),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key      (key[i]),
      .repeat_en(repeat_en[i]),
      .level    (level[i]),
      .press    (press[i]),
      .rel      (rel[i]),
      .rpt      (rpt[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with
// hand-computed per-cycle expectations.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'h0;
  logic [3:0] repeat_en = 4'h0;
  logic [3:0] level, press, rel, rpt;

  int checks = 0;
  int errors = 0;

  key_conditioner #(
    .NUM_KEYS     (4),
    .DEBOUNCE     (4),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .repeat_en(repeat_en),
    .level    (level),
    .press    (press),
    .rel      (rel),
    .rpt      (rpt)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(
    input string      t,
    input int         e,
    input logic [3:0] l,
    input logic [3:0] p,
    input logic [3:0] r,
    input logic [3:0] q
  );
    check($sformatf("%s level e%0d", t, e), level, l);
    check($sformatf("%s press e%0d", t, e), press, p);
    check($sformatf("%s rel e%0d", t, e), rel, r);
    check($sformatf("%s rpt e%0d", t, e), rpt, q);
  endtask

  function automatic logic [3:0] sel(
    input logic       c,
    input logic [3:0] v
  );
    return c ? v : 4'h0;
  endfunction

  logic [7:0] pat;

  initial begin
    // reset with every key held
    rst = 1'b1;
    key = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rst", i, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk_all("A", e, sel(e >= 5, 4'hF),
              sel(e == 5, 4'hF), 4'h0, 4'h0);
    end
    key = 4'h0;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk_all("A2", e, sel(e < 5, 4'hF), 4'h0,
              sel(e == 5, 4'hF), 4'h0);
    end
    repeat (4) tick();

    // clean press/release, no repeat
    repeat_en = 4'h0;
    for (int e = 0; e <= 40; e++) begin
      key = {3'b000, e < 30};
      tick();
      chk_all("B", e, sel(e >= 5 && e < 35, 4'h1),
              sel(e == 5, 4'h1), sel(e == 35, 4'h1),
              4'h0);
    end
    repeat (4) tick();

    // bounce: 3-run ignored, 4-run accepted
    pat = 8'b1111_0111;
    for (int e = 0; e <= 30; e++) begin
      key = {2'b00, (e < 8) ? pat[e] : (e < 20), 1'b0};
      tick();
      chk_all("C", e, sel(e >= 9 && e < 25, 4'h2),
              sel(e == 9, 4'h2), sel(e == 25, 4'h2),
              4'h0);
    end
    repeat (4) tick();

    // auto-repeat schedule
    repeat_en = 4'b0100;
    for (int e = 0; e <= 40; e++) begin
      key = {1'b0, e < 30, 2'b00};
      tick();
      chk_all("D", e, sel(e >= 5 && e < 35, 4'h4),
              sel(e == 5, 4'h4), sel(e == 35, 4'h4),
              sel(e == 13 || e == 17 || e == 21 ||
                  e == 25 || e == 29, 4'h4));
    end
    repeat_en = 4'h0;
    repeat (4) tick();

    // 2-cycle low glitch while pressed
    repeat_en = 4'b1000;
    for (int e = 0; e <= 40; e++) begin
      key = {(e < 14) || (e >= 16 && e < 30), 3'b000};
      tick();
      chk_all("E", e, sel(e >= 5 && e < 35, 4'h8),
              sel(e == 5, 4'h8), sel(e == 35, 4'h8),
              sel(e == 13 || e == 19 || e == 23 ||
                  e == 27 || e == 31, 4'h8));
    end
    repeat_en = 4'h0;
    repeat (4) tick();

    // two keys together, reset while held
    for (int e = 0; e <= 22; e++) begin
      key = 4'b1001;
      rst = (e == 11);
      tick();
      chk_all("F", e,
              sel((e >= 5 && e <= 10) || e >= 17, 4'h9),
              sel(e == 5 || e == 17, 4'h9),
              4'h0, 4'h0);
    end
    rst = 1'b0;
    key = 4'h0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Parametrised multi-channel pushbutton front end for the lab designs. Each of `NUM_KEYS` raw, active-high key inputs is synchronised, debounced and converted into a clean level plus single-cycle press, release and optional auto-repeat pulses. It sits between the board key pins (already inverted to active-high at top level) and the game/control FSMs, and replaces per-key two-state press detectors.

## Interface
- `NUM_KEYS`, 4, number of independent channels (≥1)
- `DEBOUNCE`, 4, consecutive sampled cycles a new level must hold before it is accepted (≥1)
- `REPEAT_DELAY`, 8, cycles from press acceptance to first repeat pulse (≥1)
- `REPEAT_PERIOD`, 4, cycles between subsequent repeat pulses (≥1)
- Defaults are sized for simulation; top level overrides them for the 50 MHz board clock.

- `clk` in 1 system clock; reset `rst`, synchronous, active-high
- `rst` in 1 synchronous active-high reset
- `key` in NUM_KEYS raw asynchronous key levels, 1 = pressed
- `repeat_en` in NUM_KEYS per-channel auto-repeat enable (synchronous)
- `level` out NUM_KEYS debounced key state
- `press` out NUM_KEYS one-cycle pulse on accepted press
- `release` out NUM_KEYS one-cycle pulse on accepted release
- `rpt` out NUM_KEYS one-cycle auto-repeat pulse while held

## Operation
- Per channel: 2-flop synchroniser → `s`; FSM states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; debounce counter `dcnt` (width $clog2(DEBOUNCE+1)); repeat counter `rcnt` (width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)).
- RELEASED: `s`=1 → PRESS_WAIT, `dcnt`=1; if DEBOUNCE==1 go directly to PRESSED.
- PRESS_WAIT: `s`=0 → RELEASED, `dcnt`=0; `s`=1 → `dcnt`+1; when `dcnt` reaches DEBOUNCE → PRESSED.
- PRESSED: `level`=1; `s`=0 → RELEASE_WAIT, `dcnt`=1 (DEBOUNCE==1: direct to RELEASED).
- RELEASE_WAIT: `level` stays 1; `s`=1 → back to PRESSED; DEBOUNCE consecutive zeros → RELEASED.
- `press` pulses for one cycle on entry to PRESSED from PRESS_WAIT/RELEASED only; not on return from RELEASE_WAIT.
- `release` pulses for one cycle on entry to RELEASED from PRESSED or RELEASE_WAIT.
- Repeat: `rcnt` cleared on entry to PRESSED from the release side and whenever `repeat_en`=0. It counts in PRESSED and freezes in RELEASE_WAIT. `rpt` fires at REPEAT_DELAY cycles after acceptance, then every REPEAT_PERIOD cycles.
- `press` and `rpt` never coincide. Channels are fully independent, and simultaneous events on different channels are all reported.

## Timing
- All outputs are registered; reset value of `level`, `press`, `release`, `rpt` is 0; synchroniser flops reset to 0; FSM resets to RELEASED.
- Key changing before edge k is seen by the FSM at edge k+2. The new level is accepted at edge k+1+DEBOUNCE, and outputs update after that edge (latency DEBOUNCE+2 cycles).
- With acceptance edge P: `rpt` high in the cycle after edges P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, … while in PRESSED with `repeat_en`=1.
- A glitch shorter than DEBOUNCE sampled cycles produces no output change.
- Reset mid-press clears all state with no `release` pulse. A key still held after reset is re-debounced and produces a fresh `press`.

## Structure
- Package `key_pkg`: `key_state_t` enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT).
- Sub-module `key_channel` (one synchroniser + FSM + counters, same parameters minus NUM_KEYS). The top generates NUM_KEYS instances.

## Test plan
- Reset asserted 3 cycles with all keys high → all outputs 0 during reset; `press`=0b1111 after edge 5 post-reset.
- `key[0]` high before edge 0, low before edge 30, `repeat_en`=0 → `level[0]` rises after edge 5 with one `press[0]`; falls after edge 35 with one `release[0]`; no `rpt`.
- `key[1]` bounce 1,1,1,0,1,1,1,1 → single `press[1]` only after the final 4-cycle run; the 3-cycle run yields nothing.
- `key[2]` high edges 0–29, `repeat_en[2]`=1 → `press` after edge 5, `rpt` after edges 13,17,21,25,29, `release` after edge 35.
- PRESSED key with a 2-cycle low glitch → no `release`, no second `press`; `rcnt` frozen during glitch, repeat schedule delayed 2 cycles.
- Keys 0 and 3 pressed same cycle, `rst` pulsed while held → both `press` same cycle; after reset, `level` is 0, no `release`, and re-press after 6 cycles.
